// File: rtl/sha256_pkg.sv
// Shared constants, table map and FSM state type for the SHA-256 constant fetch unit.
// H words sit at EEPROM words 0..7 and K words at 8..71.
package sha256_pkg;

  localparam int H_BASE     = 0;
  localparam int K_BASE     = 8;
  localparam int H_COUNT    = 8;
  localparam int K_COUNT    = 64;
  localparam int TABLE_LEN  = 72;
  localparam int WORD_IDX_W = $clog2(TABLE_LEN);

  localparam logic SEL_H = 1'b0;
  localparam logic SEL_K = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  function automatic logic idx_in_range(input logic sel, input logic [WORD_IDX_W-1:0] idx);
    return (sel == SEL_K) ? (int'(idx) < K_COUNT) : (int'(idx) < H_COUNT);
  endfunction

  function automatic logic [WORD_IDX_W-1:0] table_word(input logic sel,
                                                      input logic [WORD_IDX_W-1:0] idx);
    return (sel == SEL_K) ? WORD_IDX_W'(K_BASE + int'(idx)) : WORD_IDX_W'(H_BASE + int'(idx));
  endfunction

endpackage

// File: rtl/sha256_access_timer.sv
// EEPROM access timer: load starts a countdown, done pulses for one cycle so the
// owner samples data exactly ACCESS_CYCLES clocks after the load edge.
module sha256_access_timer #(
  parameter int ACCESS_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= CW'(ACCESS_CYCLES - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/sha256_const_fetch.sv
// Fetches H/K SHA-256 constants from four byte-sliced async EEPROMs and returns
// them as 32-bit words over a valid/ready handshake, singly or in bursts.
module sha256_const_fetch
  import sha256_pkg::*;
#(
  parameter int ACCESS_CYCLES = 16,
  parameter int ADDR_W        = 13
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_sel,
  input  logic [5:0]        req_idx,
  input  logic [6:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_word,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              busy,
  output logic [0:ADDR_W-1] EE_A,
  output logic              EE_CE,
  output logic              EE_OE,
  output logic              EE_WE,
  input  logic [0:7]        EE_D1,
  input  logic [0:7]        EE_D2,
  input  logic [0:7]        EE_D3,
  input  logic [0:7]        EE_D4
);

  state_t                state;
  logic                  sel;
  logic [WORD_IDX_W-1:0] cur_idx;
  logic [WORD_IDX_W-1:0] next_idx;
  logic [WORD_IDX_W-1:0] first_idx;
  logic [6:0]            beats_left;
  logic [6:0]            first_len;
  logic                  accept;
  logic                  handshake;
  logic                  burst_end;
  logic                  first_ok;
  logic                  next_ok;
  logic                  timer_load;
  logic                  timer_done;

  // The device is read-only; the write strobe can never overlap CE/OE.
  assign EE_WE = 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    accept     = (state == IDLE) && req_valid && req_ready;
    handshake  = (state == RESP) && rsp_valid && rsp_ready;
    burst_end  = (beats_left == 7'd1) || rsp_err;
    first_idx  = {1'b0, req_idx};
    next_idx   = cur_idx + WORD_IDX_W'(1);
    first_len  = (req_len == 7'd0) ? 7'd1 : req_len;
    first_ok   = idx_in_range(req_sel, first_idx);
    next_ok    = idx_in_range(sel, next_idx);
    timer_load = (accept && first_ok) || (handshake && !burst_end && next_ok);
  end

  sha256_access_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk (CLK),
    .rst (RST),
    .load(timer_load),
    .done(timer_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      sel        <= SEL_H;
      cur_idx    <= '0;
      beats_left <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_word   <= '0;
      rsp_err    <= 1'b0;
      rsp_last   <= 1'b0;
      busy       <= 1'b0;
      EE_A       <= '0;
      EE_CE      <= 1'b1;
      EE_OE      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            sel        <= req_sel;
            cur_idx    <= first_idx;
            beats_left <= first_len;
            if (first_ok) begin
              EE_A  <= ADDR_W'(table_word(req_sel, first_idx));
              EE_CE <= 1'b0;
              EE_OE <= 1'b0;
              state <= ACCESS;
            end else begin
              rsp_valid <= 1'b1;
              rsp_word  <= '0;
              rsp_err   <= 1'b1;
              rsp_last  <= 1'b1;
              state     <= RESP;
            end
          end
        end

        ACCESS: begin
          if (timer_done) begin
            rsp_word  <= {EE_D1, EE_D2, EE_D3, EE_D4};
            rsp_err   <= 1'b0;
            rsp_last  <= (beats_left == 7'd1);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (handshake) begin
            if (burst_end) begin
              rsp_valid <= 1'b0;
              rsp_err   <= 1'b0;
              rsp_last  <= 1'b0;
              EE_CE     <= 1'b1;
              EE_OE     <= 1'b1;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              cur_idx    <= next_idx;
              beats_left <= beats_left - 7'd1;
              if (next_ok) begin
                EE_A      <= ADDR_W'(table_word(sel, next_idx));
                rsp_valid <= 1'b0;
                state     <= ACCESS;
              end else begin
                // Burst ran off the end of its table: close with an error beat.
                rsp_word <= '0;
                rsp_err  <= 1'b1;
                rsp_last <= 1'b1;
                EE_CE    <= 1'b1;
                EE_OE    <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_const_fetch.sv
// Bench for sha256_const_fetch: timed EEPROM model, directed scenarios and a
// randomized burst run checked against a table-level reference model.
module tb_sha256_const_fetch;
  import sha256_pkg::*;

  localparam logic [31:0] H_TAB [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct packed {
    logic [31:0] word;
    logic        err;
    logic        last;
    logic        unstable;
    logic [15:0] lat;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_sel;
  logic [5:0]  req_idx;
  logic [6:0]  req_len;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_word;
  logic        rsp_err, rsp_last, busy;
  logic [0:12] EE_A;
  logic        EE_CE, EE_OE, EE_WE;
  logic [0:7]  ee_d1, ee_d2, ee_d3, ee_d4;

  int passed = 0;
  int total  = 0;

  sha256_const_fetch #(.ACCESS_CYCLES(16), .ADDR_W(13)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_idx(req_idx), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
    .EE_A(EE_A), .EE_CE(EE_CE), .EE_OE(EE_OE), .EE_WE(EE_WE),
    .EE_D1(ee_d1), .EE_D2(ee_d2), .EE_D3(ee_d3), .EE_D4(ee_d4)
  );

  always #5 CLK = ~CLK;

  // EEPROM model: data is only correct once address/CE/OE have been stable 150 ns.
  time         last_change = 0;
  logic [31:0] ee_data = 32'hdeadbeef;
  int unsigned ee_addr;

  always @(EE_A or EE_CE or EE_OE) last_change = $time;

  initial begin
    forever begin
      #1;
      ee_addr = int'(EE_A);
      if (EE_CE || EE_OE || ($time - last_change < 150)) ee_data = 32'hdeadbeef;
      else if (ee_addr < 8) ee_data = H_TAB[ee_addr];
      else if (ee_addr < 72) ee_data = K_TAB[ee_addr - 8];
      else ee_data = 32'hdeadbeef;
    end
  end

  assign ee_d1 = ee_data[31:24];
  assign ee_d2 = ee_data[23:16];
  assign ee_d3 = ee_data[15:8];
  assign ee_d4 = ee_data[7:0];

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1);
  end

  // Reference: walk the requested words through the table, ending early with one error beat.
  function automatic void model(input logic s, input int idx, input int len, output beat_t q[$]);
    int    n;
    beat_t b;
    q = {};
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      b = '0;
      if (idx + i < (s ? 64 : 8)) begin
        b.word = s ? K_TAB[idx + i] : H_TAB[idx + i];
        b.last = (i == n - 1);
        q.push_back(b);
      end else begin
        b.err  = 1'b1;
        b.last = 1'b1;
        q.push_back(b);
        break;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_req(input logic s, input logic [5:0] i, input logic [6:0] l, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (req_ready) begin
      req_sel   = s;
      req_idx   = i;
      req_len   = l;
      req_valid = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  // Drains beats until the one flagged last; lat counts edges from accept/handshake to visibility.
  task automatic collect(input bit rand_ready, output beat_t beats[$],
                         output int ce_low, output int ce_high, output bit timeout);
    beat_t b;
    bit    pending;
    int    lat;
    beats   = {};
    ce_low  = 0;
    ce_high = 0;
    timeout = 1'b1;
    pending = 1'b0;
    lat     = 1;
    b       = '0;
    for (int guard = 0; guard < 600; guard++) begin
      if (EE_CE) ce_high++; else ce_low++;
      rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rsp_valid) begin
        if (!pending) begin
          pending    = 1'b1;
          b.word     = rsp_word;
          b.err      = rsp_err;
          b.last     = rsp_last;
          b.unstable = 1'b0;
          b.lat      = 16'(lat);
        end else if ({rsp_word, rsp_err, rsp_last} != {b.word, b.err, b.last}) begin
          b.unstable = 1'b1;
        end
        if (rsp_ready) begin
          beats.push_back(b);
          pending = 1'b0;
          lat     = 0;
          if (b.last) begin
            @(negedge CLK);
            timeout = 1'b0;
            break;
          end
        end
      end
      @(negedge CLK);
      lat++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else passed++;
    total++; if (rsp_word !== 32'h0) $display("FAIL rst_rsp_word got %h exp 0", rsp_word); else passed++;
    total++; if ({rsp_err, rsp_last, busy} !== 3'b000) $display("FAIL rst_err_last_busy got %b exp 000", {rsp_err, rsp_last, busy}); else passed++;
    total++; if (EE_A !== 13'd0) $display("FAIL rst_ee_a got %0d exp 0", EE_A); else passed++;
    total++; if ({EE_CE, EE_OE, EE_WE} !== 3'b111) $display("FAIL rst_ee_ctl got %b exp 111", {EE_CE, EE_OE, EE_WE}); else passed++;
    RST = 1'b0;
    @(negedge CLK);
    total++; if (req_ready !== 1'b1) $display("FAIL post_rst_req_ready got %b exp 1", req_ready); else passed++;
  endtask

  task automatic test_single_h();
    beat_t got[$];
    bit ok, to;
    int lo, hi;
    send_req(SEL_H, 6'd0, 7'd1, ok);
    total++; if (!ok) $display("FAIL h0_accept got req_ready=0 exp 1"); else passed++;
    collect(1'b0, got, lo, hi, to);
    total++; if (to || got.size() != 1) $display("FAIL h0_beats got %0d (timeout %0d) exp 1", got.size(), to); else passed++;
    if (got.size() > 0) begin
      total++; if ({got[0].word, got[0].err, got[0].last} !== {32'h6a09e667, 2'b01}) $display("FAIL h0_word got %h err %b last %b exp 6a09e667 0 1", got[0].word, got[0].err, got[0].last); else passed++;
      total++; if (got[0].lat !== 16'd17) $display("FAIL h0_latency got %0d exp 17", got[0].lat); else passed++;
    end
  endtask

  task automatic test_burst_k();
    logic [33:0] exp_b [4];
    beat_t got[$];
    bit ok, to;
    int lo, hi;
    exp_b[0] = {32'h428a2f98, 2'b00};
    exp_b[1] = {32'h71374491, 2'b00};
    exp_b[2] = {32'hb5c0fbcf, 2'b00};
    exp_b[3] = {32'he9b5dba5, 2'b01};
    send_req(SEL_K, 6'd0, 7'd4, ok);
    collect(1'b0, got, lo, hi, to);
    total++; if (!ok || to || got.size() != 4) $display("FAIL k_burst_beats got %0d exp 4", got.size()); else passed++;
    for (int k = 0; k < got.size() && k < 4; k++) begin
      total++; if ({got[k].word, got[k].err, got[k].last} !== exp_b[k]) $display("FAIL k_burst_beat%0d got %h exp %h", k, {got[k].word, got[k].err, got[k].last}, exp_b[k]); else passed++;
      total++; if (got[k].lat !== 16'd17) $display("FAIL k_burst_lat%0d got %0d exp 17", k, got[k].lat); else passed++;
    end
    total++; if (hi != 0) $display("FAIL k_burst_ce got %0d cycles high exp 0", hi); else passed++;
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    send_req(SEL_K, 6'd63, 7'd1, ok);
    n = 1;
    while (!rsp_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    total++; if (!ok || n != 17) $display("FAIL stall_first_valid got cycle %0d exp 17", n); else passed++;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      total++; if ({rsp_valid, rsp_word, rsp_last} !== {1'b1, 32'hc67178f2, 1'b1}) $display("FAIL stall_hold%0d got v%b %h l%b exp v1 c67178f2 l1", c, rsp_valid, rsp_word, rsp_last); else passed++;
      total++; if (EE_A !== 13'd71) $display("FAIL stall_ee_a%0d got %0d exp 71", c, EE_A); else passed++;
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, busy, req_ready} !== 3'b001) $display("FAIL stall_release got %b exp 001", {rsp_valid, busy, req_ready}); else passed++;
  endtask

  task automatic test_err_h();
    beat_t got[$];
    bit ok, to;
    int lo, hi;
    send_req(SEL_H, 6'd8, 7'd1, ok);
    collect(1'b0, got, lo, hi, to);
    total++; if (!ok || to || got.size() != 1) $display("FAIL h8_beats got %0d exp 1", got.size()); else passed++;
    if (got.size() > 0) begin
      total++; if ({got[0].word, got[0].err, got[0].last} !== {32'h0, 2'b11}) $display("FAIL h8_err_beat got %h err %b last %b exp 0 1 1", got[0].word, got[0].err, got[0].last); else passed++;
      total++; if (got[0].lat !== 16'd1) $display("FAIL h8_latency got %0d exp 1", got[0].lat); else passed++;
    end
    total++; if (lo != 0 || EE_CE !== 1'b1) $display("FAIL h8_ce got %0d low cycles exp 0", lo); else passed++;
  endtask

  task automatic test_burst_overrun();
    logic [33:0] exp_b [3];
    beat_t got[$];
    bit ok, to;
    int lo, hi;
    exp_b[0] = {32'hbef9a3f7, 2'b00};
    exp_b[1] = {32'hc67178f2, 2'b00};
    exp_b[2] = {32'h00000000, 2'b11};
    send_req(SEL_K, 6'd62, 7'd4, ok);
    collect(1'b0, got, lo, hi, to);
    total++; if (!ok || to || got.size() != 3) $display("FAIL overrun_beats got %0d exp 3", got.size()); else passed++;
    for (int k = 0; k < got.size() && k < 3; k++) begin
      total++; if ({got[k].word, got[k].err, got[k].last} !== exp_b[k]) $display("FAIL overrun_beat%0d got %h exp %h", k, {got[k].word, got[k].err, got[k].last}, exp_b[k]); else passed++;
    end
    if (got.size() == 3) begin
      total++; if (got[2].lat !== 16'd1) $display("FAIL overrun_err_latency got %0d exp 1", got[2].lat); else passed++;
    end
    total++; if ({busy, req_ready, rsp_valid} !== 3'b010) $display("FAIL overrun_idle got %b exp 010", {busy, req_ready, rsp_valid}); else passed++;
  endtask

  task automatic test_reset_mid_access();
    beat_t got[$];
    bit ok, to;
    int lo, hi;
    send_req(SEL_H, 6'd3, 7'd2, ok);
    repeat (5) @(negedge CLK);
    total++; if ({busy, EE_CE} !== 2'b10) $display("FAIL mid_access_state got %b exp 10", {busy, EE_CE}); else passed++;
    RST = 1'b1;
    @(negedge CLK);
    total++; if ({EE_CE, EE_OE, rsp_valid, busy, req_ready} !== 5'b11000) $display("FAIL mid_rst_outputs got %b exp 11000", {EE_CE, EE_OE, rsp_valid, busy, req_ready}); else passed++;
    RST = 1'b0;
    @(negedge CLK);
    send_req(SEL_H, 6'd7, 7'd1, ok);
    collect(1'b0, got, lo, hi, to);
    total++; if (!ok || to || got.size() != 1) $display("FAIL after_rst_beats got %0d exp 1", got.size()); else passed++;
    if (got.size() > 0) begin
      total++; if ({got[0].word, got[0].err, got[0].last} !== {32'h5be0cd19, 2'b01}) $display("FAIL after_rst_word got %h exp 5be0cd19", got[0].word); else passed++;
    end
  endtask

  task automatic test_random();
    beat_t got[$], exp_q[$];
    bit ok, to;
    int lo, hi;
    logic       s;
    logic [5:0] idx;
    logic [6:0] len;
    for (int r = 0; r < 20; r++) begin
      s   = 1'($urandom_range(0, 1));
      idx = s ? 6'(($urandom_range(0, 1) != 0) ? $urandom_range(56, 63) : $urandom_range(0, 63))
              : 6'($urandom_range(0, 11));
      len = 7'($urandom_range(0, 6));
      model(s, int'(idx), int'(len), exp_q);
      send_req(s, idx, len, ok);
      total++; if (!ok) $display("FAIL rand%0d_accept got req_ready=0 exp 1", r); else passed++;
      if (ok) begin
        collect(1'b1, got, lo, hi, to);
        total++; if (to || got.size() != exp_q.size()) $display("FAIL rand%0d_beats got %0d exp %0d (sel %0d idx %0d len %0d)", r, got.size(), exp_q.size(), s, idx, len); else passed++;
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
          total++; if ({got[k].word, got[k].err, got[k].last} !== {exp_q[k].word, exp_q[k].err, exp_q[k].last}) $display("FAIL rand%0d_beat%0d got %h exp %h", r, k, {got[k].word, got[k].err, got[k].last}, {exp_q[k].word, exp_q[k].err, exp_q[k].last}); else passed++;
          total++; if (got[k].unstable !== 1'b0) $display("FAIL rand%0d_hold%0d got changed exp stable", r, k); else passed++;
        end
      end
    end
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 1'b0;
    req_sel   = 1'b0;
    req_idx   = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single_h();
    test_burst_k();
    test_stall();
    test_err_h();
    test_burst_overrun();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
